// File: rtl/nf10_axis_256to64_converter.sv
// rtl/nf10_axis_256to64_converter.sv - 256-bit to 64-bit AXI4-Stream egress width converter
// Holds one input word and replays its lanes low-to-high, trimming lanes past the packet tail.
module nf10_axis_256to64_converter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_count
);

  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                            state_q, state_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    data_q, data_d;
  logic [SW-1:0]                     tstrb_q, tstrb_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                              tlast_q, tlast_d;
  logic [1:0]                        lane_idx_q, lane_idx_d;
  logic [1:0]                        last_lane_q, last_lane_d;
  logic [31:0]                       pkt_count_q, pkt_count_d;
  logic                              rst_done_q;
  logic                              in_hs, out_hs, on_last_lane;

  function automatic logic [1:0] hi_lane(input logic [SW-1:0] strb);
    if (|strb[31:24])      return 2'd3;
    else if (|strb[23:16]) return 2'd2;
    else if (|strb[15:8])  return 2'd1;
    else                   return 2'd0;
  endfunction

  assign on_last_lane  = (lane_idx_q == last_lane_q);
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = data_q[{lane_idx_q, 6'd0} +: C_M_AXIS_DATA_WIDTH];
  assign m_axis_tstrb  = tstrb_q[{lane_idx_q, 3'd0} +: C_M_AXIS_DATA_WIDTH/8];
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = m_axis_tvalid && tlast_q && on_last_lane;
  // Combinational through m_axis_tready so the next word lands in the same edge as the final beat.
  assign s_axis_tready = rst_done_q && ((state_q == EMPTY) || (m_axis_tready && on_last_lane));
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign pkt_count     = pkt_count_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tstrb_d     = tstrb_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    lane_idx_d  = lane_idx_q;
    last_lane_d = last_lane_q;
    pkt_count_d = pkt_count_q;
    if (out_hs) begin
      if (!on_last_lane) lane_idx_d = lane_idx_q + 2'd1;
      else               state_d    = EMPTY;
      if (m_axis_tlast)  pkt_count_d = pkt_count_q + 32'd1;
    end
    if (in_hs) begin
      data_d      = s_axis_tdata;
      tstrb_d     = s_axis_tstrb;
      tuser_d     = s_axis_tuser;
      tlast_d     = s_axis_tlast;
      lane_idx_d  = 2'd0;
      last_lane_d = s_axis_tlast ? hi_lane(s_axis_tstrb) : 2'd3;
      state_d     = SEND;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      tstrb_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      lane_idx_q  <= 2'd0;
      last_lane_q <= 2'd0;
      pkt_count_q <= 32'd0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      tstrb_q     <= tstrb_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      lane_idx_q  <= lane_idx_d;
      last_lane_q <= last_lane_d;
      pkt_count_q <= pkt_count_d;
      rst_done_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nf10_axis_256to64_converter.sv
// tb/tb_nf10_axis_256to64_converter.sv - scoreboard bench for the 256-to-64 converter
module tb_nf10_axis_256to64_converter;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid, s_tready, s_tlast;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  pkt_count;

  always #5 clk = ~clk;

  nf10_axis_256to64_converter dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   s;
    logic [127:0] u;
    logic         l;
    logic         wend;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    beats_seen = 0;
  int    pkts_sent = 0;
  bit    rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [255:0] d, input logic [31:0] s,
                           input logic [127:0] u, input logic l);
    int ll;
    ll = 3;
    if (l) begin
      ll = 0;
      for (int i = 0; i < 4; i++) if (s[8*i +: 8] != 8'h00) ll = i;
    end
    for (int i = 0; i <= ll; i++)
      exp_q.push_back('{d: d[64*i +: 64], s: s[8*i +: 8], u: u, l: (l && i == ll), wend: (i == ll)});
    if (l) pkts_sent++;
  endtask

  task automatic send_word(input logic [255:0] d, input logic [31:0] s,
                           input logic [127:0] u, input logic l);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tstrb = s; s_tuser = u; s_tlast = l;
    while (!hs) begin
      @(negedge clk);
      hs = s_tready;
      if (hs) push_word(d, s, u, l);
      @(posedge clk); #1;
      n++;
      if (!hs && n > 300) begin
        errors++; checks++;
        $display("FAIL send_timeout: got no s_tready expected handshake");
        break;
      end
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending beats expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // output ready: held high, or coin-flip each cycle
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: compares each presented beat against the scoreboard head
  initial begin
    beat_t        e;
    logic         stall_prev;
    logic [201:0] saved;
    stall_prev = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stable", {m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser}, saved);
        if (m_tvalid) begin
          if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_beat: got data %h expected no beat", m_tdata);
          end else begin
            e = exp_q[0];
            chk("s_tready", s_tready, m_tready && e.wend);
            if (m_tready) begin
              e = exp_q.pop_front();
              chk("tdata", m_tdata, e.d);
              chk("tstrb", m_tstrb, e.s);
              chk("tuser", m_tuser, e.u);
              chk("tlast", m_tlast, e.l);
              beats_seen++;
            end
          end
        end
        stall_prev = m_tvalid && !m_tready;
        saved = {m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser};
      end
    end
  end

  initial begin
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  s;
    int           nw, nb, b0, n;

    // reset release with a word already offered
    aresetn = 1'b0;
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tstrb = 32'hFFFF_FFFF;
    s_tdata = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
               64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    s_tuser = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    repeat (3) @(posedge clk);
    #2 aresetn = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, 64'h0);
    chk("rst_m_tstrb", m_tstrb, 8'h0);
    chk("rst_m_tuser", m_tuser, 128'h0);
    chk("rst_pkt_count", pkt_count, 32'h0);
    @(negedge clk);
    chk("rel_s_tready", s_tready, 1'b1);
    push_word(s_tdata, s_tstrb, s_tuser, s_tlast);
    @(posedge clk); #1;
    idle();
    drain();
    chk("pkt_after_first", pkt_count, pkts_sent);

    // two-word full packet, back-to-back
    u = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    send_word({64'h1003, 64'h1002, 64'h1001, 64'h1000}, 32'hFFFF_FFFF, u, 1'b0);
    send_word({64'h2003, 64'h2002, 64'h2001, 64'h2000}, 32'hFFFF_FFFF, u, 1'b1);
    idle();
    drain();
    chk("pkt_full", pkt_count, pkts_sent);

    // non-last word with empty upper lanes, then short tail
    send_word({64'h3003, 64'h3002, 64'h3001, 64'h3000}, 32'h0000_FFFF, u, 1'b0);
    send_word({64'h4003, 64'h4002, 64'h4001, 64'h4000}, 32'h0000_07FF, u, 1'b1);
    // all-zero strobe last word
    send_word({64'h5003, 64'h5002, 64'h5001, 64'h5000}, 32'h0000_0000, ~u, 1'b1);
    // non-contiguous strobes: highest set lane is 2
    send_word({64'h6003, 64'h6002, 64'h6001, 64'h6000}, 32'h0001_0001, u, 1'b1);
    idle();
    drain();
    chk("pkt_short", pkt_count, pkts_sent);

    // random packets under random backpressure
    rnd_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      nw = $urandom_range(1, 2);
      u  = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < nw; w++) begin
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (w == nw - 1) begin
          nb = $urandom_range(0, 32);
          s = (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
        end else begin
          s = 32'hFFFF_FFFF;
        end
        send_word(d, s, u, (w == nw - 1));
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(posedge clk); #1;
        end
      end
    end
    idle();
    drain();
    chk("pkt_random", pkt_count, pkts_sent);

    // reset in the middle of a word
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b0 = beats_seen;
    send_word({64'h7003, 64'h7002, 64'h7001, 64'h7000}, 32'hFFFF_FFFF, u, 1'b1);
    idle();
    n = 0;
    while (beats_seen < b0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_beats", beats_seen, b0 + 2);
    @(posedge clk);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_m_tvalid", m_tvalid, 1'b0);
    chk("mid_pkt_count", pkt_count, 32'h0);
    exp_q.delete();
    pkts_sent = 0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_word({64'h8003, 64'h8002, 64'h8001, 64'h8000}, 32'h0000_00FF, u, 1'b1);
    idle();
    drain();
    chk("pkt_after_mid_reset", pkt_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
